pc_fetch_sequencer: RTL

Sequential fetch controller wrapping the program counter. Owns the PC register, sequences instruction-memory requests over a req/ack handshake, and selects the next PC from PC+4, a branch/jump redirect, or the trap vector. Sits between the decode/execute stages (stall, redirect, halt) and instruction memory.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/pc_fetch_sequencer_pc_plus4.sv | 12 +
 rtl/pc_fetch_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// Holds the sequencer state encoding, alignment/step constants and default vectors.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDeliver,
        StHalted
    } seq_state_e;

    localparam logic [1:0]  ALIGN_MASK  = 2'b11;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_pc_plus4.sv
// Sequential-PC incrementer: the only adder in the fetch path.
// Wraps modulo 2^32 with no carry out.
module pc_fetch_sequencer_pc_plus4
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + INSTR_BYTES;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: owns the PC, runs the imem req/ack handshake and picks the next PC
// from PC+4, a redirect target, or the trap vector on a misaligned redirect.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        trap_taken,
    output logic        halted
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        pending_q, pending_d;
    logic [31:0] pending_target_q, pending_target_d;
    logic        trap_q, trap_d;

    logic [31:0] pc_plus4;
    logic        apply_redirect;
    logic [31:0] apply_target;

    pc_fetch_sequencer_pc_plus4 u_pc_plus4 (
        .pc       (pc_q),
        .pc_plus4 (pc_plus4)
    );

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        instr_d          = instr_q;
        pending_d        = pending_q;
        pending_target_d = pending_target_q;
        trap_d           = 1'b0;
        apply_redirect   = 1'b0;
        apply_target     = pending_target_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                // Address stays put until ack; redirects are parked and a newer one wins.
                if (redirect_valid) begin
                    pending_d        = 1'b1;
                    pending_target_d = redirect_target;
                end
                if (imem_ack) begin
                    if (redirect_valid || pending_q) begin
                        apply_redirect = 1'b1;
                        apply_target   = redirect_valid ? redirect_target : pending_target_q;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = StDeliver;
                    end
                end
            end
            StDeliver: begin
                if (halt) begin
                    state_d = StHalted;
                end else if (redirect_valid) begin
                    apply_redirect = 1'b1;
                    apply_target   = redirect_target;
                    state_d        = StReq;
                end else if (!stall) begin
                    pc_d    = pc_plus4;
                    state_d = StReq;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (apply_redirect) begin
            pending_d = 1'b0;
            if (is_word_aligned(apply_target)) begin
                pc_d = apply_target;
            end else begin
                pc_d   = TRAP_VECTOR;
                trap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            pc_q             <= RESET_VECTOR;
            instr_q          <= 32'h0;
            pending_q        <= 1'b0;
            pending_target_q <= 32'h0;
            trap_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            instr_q          <= instr_d;
            pending_q        <= pending_d;
            pending_target_q <= pending_target_d;
            trap_q           <= trap_d;
        end
    end

    assign imem_req    = (state_q == StReq);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == StDeliver);
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pcPlus4     = pc_plus4;
    assign trap_taken  = trap_q;
    assign halted      = (state_q == StHalted);

endmodule
